exc_sequencer: RTL and testbench
================================

# exc_sequencer

Exception-entry and ERET sequencer between the memory (M) stage of the pipeline and the CP0 register block. It decides when a pending interrupt, an M-stage exception or an M-stage ERET is taken. It drives the one-cycle CP0 update strobes (EXL set/clear with code, victim PC, BD, bad address) and flushes and holds the pipeline. It then redirects fetch to the handler or to EPC through a valid/ready handshake.

## Interface
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address
- DRAIN_CYCLES, 2, flush cycles after redirect accept before returning to IDLE (0..15)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m_valid  in  1  M stage holds a real instruction (not a bubble)
- m_pc  in  32  PC of M-stage instruction
- m_bd  in  1  M-stage instruction is in a delay slot
- m_exc  in  1  M-stage instruction carries an exception
- m_exc_code  in  5  its ExcCode
- m_vaddr  in  32  faulting address (AdEL/AdES)
- m_eret  in  1  M-stage instruction is ERET
- irq  in  1  masked interrupt request from CP0 (level)
- cp0_exl  in  1  current CP0 EXL
- cp0_epc  in  32  current CP0 EPC
- redirect_ready  in  1  fetch accepts redirect
- kill_m  out  1  combinational: suppress M-stage side effects this cycle
- stall  out  1  hold all stages (state != IDLE)
- flush  out  1  invalidate all pipeline stages
- cp0_exl_set  out  1  one-cycle exception-entry strobe
- cp0_exl_clr  out  1  one-cycle ERET strobe
- cp0_vpc  out  32  victim PC
- cp0_bd  out  1  victim BD
- cp0_exc_code  out  5  code (0 for interrupt)
- cp0_vaddr  out  32  bad address
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  redirect target
- event_cnt  out  16  count of taken events, wraps at 16'hFFFF -> 0

## Operation
- States: IDLE, COMMIT, REDIRECT, DRAIN.
- IDLE: an event is taken only when m_valid=1. Priority is INT (irq & !cp0_exl) > EXC (m_exc) > ERET (m_eret & !m_exc).
- When an event is taken, kill_m=1 combinationally in that cycle. The block latches the type, m_pc, m_bd, code (INT -> 5'd0), m_vaddr and cp0_epc, then goes to COMMIT. event_cnt increments.
- COMMIT (exactly 1 cycle): INT/EXC -> cp0_exl_set=1. ERET -> cp0_exl_clr=1. cp0_vpc, cp0_bd, cp0_exc_code and cp0_vaddr present the latched values. flush=1. Next state is REDIRECT.
- REDIRECT: redirect_valid=1. redirect_pc = HANDLER_PC (INT/EXC) or latched EPC (ERET); it is stable until accepted. flush=1. On redirect_ready=1 -> DRAIN (or IDLE if DRAIN_CYCLES=0).
- DRAIN: flush=1 and the counter loads DRAIN_CYCLES-1 and decrements. Leave to IDLE in the cycle after the counter reads 0.
- stall=1 in every state except IDLE. Inputs other than redirect_ready are ignored outside IDLE.
- cp0_vpc, cp0_bd, cp0_exc_code and cp0_vaddr hold their last latched values between events. Only the strobes are pulses.

## Timing
- Reset values: state IDLE. All 1-bit outputs 0. cp0_vpc, cp0_vaddr, redirect_pc, cp0_exc_code and event_cnt are 0.
- Event sampled at edge T (IDLE) -> strobe during cycle T+1 -> redirect_valid from T+2.
- With redirect_ready tied high: redirect accepted in T+2, DRAIN for T+3..T+2+DRAIN_CYCLES, IDLE at T+3+DRAIN_CYCLES.
- The strobe never lasts more than 1 cycle. cp0_exl_set and cp0_exl_clr are never high together.
- irq with m_valid=0 waits. No kill, no state change until a valid M instruction.
- irq held through an entire sequence: no retake after return unless cp0_exl=0 in IDLE.
- m_exc and m_eret together: treated as EXC.
- reset in any state: IDLE next cycle, strobes and redirect_valid drop immediately at that edge, event_cnt=0.

## Test plan
- EXC: m_valid=1, m_exc=1, code=5'd12, m_pc=32'h3010, m_bd=0 -> kill_m same cycle. The next cycle has cp0_exl_set=1, code 12, vpc 32'h3010. The cycle after has redirect_valid=1 with pc 32'h4180. With ready=1, IDLE returns 4 cycles after the event edge (DRAIN_CYCLES=2).
- INT beats EXC: irq=1, cp0_exl=0, m_exc=1 code 5'd4 in the same cycle -> cp0_exc_code=0, vaddr latched, event_cnt+1.
- ERET: m_eret=1, cp0_epc=32'h3020 -> cp0_exl_clr pulse, cp0_exl_set stays 0, redirect_pc=32'h3020.
- Backpressure: redirect_ready=0 for 5 cycles -> redirect_valid and pc stable, stall=1 and flush=1 throughout. Accept on the 6th cycle, then DRAIN.
- Masking/bubble: irq=1 with cp0_exl=1 -> no event. irq=1 with m_valid=0 for 3 cycles -> kill_m stays 0, and the event is taken on the first m_valid=1.
- Reset during REDIRECT -> the next cycle is IDLE with all outputs at their reset values. event_cnt wraps 16'hFFFF -> 0 after a forced count.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer
//   Decides when a pending interrupt, an M-stage exception or an M-stage ERET
//   is taken. It pulses the CP0 update strobes for one cycle, holds and
//   flushes the pipeline, and then redirects fetch to the handler or to EPC.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   m_valid .. m_eret   M-stage instruction status (valid, pc, bd, exc, code,
//                       faulting address, eret)
//   irq, cp0_exl        masked interrupt request and current EXL
//   cp0_epc             current EPC, used as the ERET target
//   redirect_ready      fetch accepts the redirect
//   kill_m              combinational: suppress M-stage side effects now
//   stall, flush        hold / invalidate the pipeline while busy
//   cp0_exl_set/clr     one-cycle entry / ERET strobes
//   cp0_vpc, cp0_bd,
//   cp0_exc_code,
//   cp0_vaddr           latched victim info, held between events
//   redirect_valid/pc   fetch redirect request
//   event_cnt           taken-event counter, wraps
//   dbg_state           current FSM state (0 IDLE, 1 COMMIT, 2 REDIRECT, 3 DRAIN)
//
// Handshake: redirect_valid rises in REDIRECT and stays high with a stable
// redirect_pc until a cycle in which redirect_ready is also high; the
// transfer happens at that clock edge and valid drops in the next cycle.

module exc_sequencer #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic [31:0] m_vaddr,
  input  logic        m_eret,
  input  logic        irq,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc,
  input  logic        redirect_ready,
  output logic        kill_m,
  output logic        stall,
  output logic        flush,
  output logic        cp0_exl_set,
  output logic        cp0_exl_clr,
  output logic [31:0] cp0_vpc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exc_code,
  output logic [31:0] cp0_vaddr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [15:0] event_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  // The drain counter counts down to zero, so it is loaded with one less
  // than the number of drain cycles.
  localparam logic [3:0] DRAIN_LOAD =
    (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic        exl_set_q, exl_set_d;
  logic        exl_clr_q, exl_clr_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] vpc_q, vpc_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [15:0] event_cnt_q, event_cnt_d;

  logic int_take;
  logic is_eret;
  logic ev_take;

  // Priority INT > EXC > ERET; an ERET that also carries an exception is an
  // exception.
  assign int_take = irq & ~cp0_exl;
  assign is_eret  = ~int_take & ~m_exc & m_eret;
  assign ev_take  = (state_q == S_IDLE) & m_valid & (int_take | m_exc | m_eret);

  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    exl_set_d        = 1'b0;
    exl_clr_d        = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    vpc_d            = vpc_q;
    bd_d             = bd_q;
    code_d           = code_q;
    vaddr_d          = vaddr_q;
    event_cnt_d      = event_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ev_take) begin
          state_d       = S_COMMIT;
          vpc_d         = m_pc;
          bd_d          = m_bd;
          code_d        = int_take ? 5'd0 : m_exc_code;
          vaddr_d       = m_vaddr;
          // The target is fixed now so it stays stable through REDIRECT.
          redirect_pc_d = is_eret ? cp0_epc : HANDLER_PC;
          exl_set_d     = ~is_eret;
          exl_clr_d     = is_eret;
          event_cnt_d   = event_cnt_q + 16'd1;
        end
      end
      S_COMMIT: begin
        state_d          = S_REDIRECT;
        redirect_valid_d = 1'b1;
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          state_d     = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          redirect_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      drain_cnt_q      <= 4'd0;
      exl_set_q        <= 1'b0;
      exl_clr_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      vpc_q            <= 32'd0;
      bd_q             <= 1'b0;
      code_q           <= 5'd0;
      vaddr_q          <= 32'd0;
      event_cnt_q      <= 16'd0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      exl_set_q        <= exl_set_d;
      exl_clr_q        <= exl_clr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      vpc_q            <= vpc_d;
      bd_q             <= bd_d;
      code_q           <= code_d;
      vaddr_q          <= vaddr_d;
      event_cnt_q      <= event_cnt_d;
    end
  end

  assign kill_m         = ev_take;
  assign stall          = (state_q != S_IDLE);
  assign flush          = (state_q != S_IDLE);
  assign cp0_exl_set    = exl_set_q;
  assign cp0_exl_clr    = exl_clr_q;
  assign cp0_vpc        = vpc_q;
  assign cp0_bd         = bd_q;
  assign cp0_exc_code   = code_q;
  assign cp0_vaddr      = vaddr_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign event_cnt      = event_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer (HANDLER_PC 32'h4180, DRAIN_CYCLES 2).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_exc;
  logic [4:0]  m_exc_code;
  logic [31:0] m_vaddr;
  logic        m_eret;
  logic        irq;
  logic        cp0_exl;
  logic [31:0] cp0_epc;
  logic        redirect_ready;
  logic        kill_m;
  logic        stall;
  logic        flush;
  logic        cp0_exl_set;
  logic        cp0_exl_clr;
  logic [31:0] cp0_vpc;
  logic        cp0_bd;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_vaddr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] event_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  exc_sequencer #(
    .HANDLER_PC  (32'h0000_4180),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_valid       (m_valid),
    .m_pc          (m_pc),
    .m_bd          (m_bd),
    .m_exc         (m_exc),
    .m_exc_code    (m_exc_code),
    .m_vaddr       (m_vaddr),
    .m_eret        (m_eret),
    .irq           (irq),
    .cp0_exl       (cp0_exl),
    .cp0_epc       (cp0_epc),
    .redirect_ready(redirect_ready),
    .kill_m        (kill_m),
    .stall         (stall),
    .flush         (flush),
    .cp0_exl_set   (cp0_exl_set),
    .cp0_exl_clr   (cp0_exl_clr),
    .cp0_vpc       (cp0_vpc),
    .cp0_bd        (cp0_bd),
    .cp0_exc_code  (cp0_exc_code),
    .cp0_vaddr     (cp0_vaddr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .event_cnt     (event_cnt),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_m();
    m_valid    = 1'b0;
    m_pc       = 32'd0;
    m_bd       = 1'b0;
    m_exc      = 1'b0;
    m_exc_code = 5'd0;
    m_vaddr    = 32'd0;
    m_eret     = 1'b0;
  endtask

  initial begin
    // Reset
    clear_m();
    irq            = 1'b0;
    cp0_exl        = 1'b0;
    cp0_epc        = 32'd0;
    redirect_ready = 1'b1;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_kill", 32'(kill_m), 32'd0);
    chk("rst_set", 32'(cp0_exl_set), 32'd0);
    chk("rst_clr", 32'(cp0_exl_clr), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_vpc", cp0_vpc, 32'd0);
    chk("rst_vaddr", cp0_vaddr, 32'd0);
    chk("rst_code", 32'(cp0_exc_code), 32'd0);
    chk("rst_cnt", 32'(event_cnt), 32'd0);

    // EXC: code 12 at 32'h3010
    m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd12; m_pc = 32'h3010;
    m_bd = 1'b0; m_vaddr = 32'hA5A5_0001;
    #1;
    chk("exc_kill", 32'(kill_m), 32'd1);
    chk("exc_stall_pre", 32'(stall), 32'd0);
    tick();
    clear_m();
    #1;
    chk("exc_set", 32'(cp0_exl_set), 32'd1);
    chk("exc_clr", 32'(cp0_exl_clr), 32'd0);
    chk("exc_code", 32'(cp0_exc_code), 32'd12);
    chk("exc_vpc", cp0_vpc, 32'h3010);
    chk("exc_bd", 32'(cp0_bd), 32'd0);
    chk("exc_vaddr", cp0_vaddr, 32'hA5A5_0001);
    chk("exc_flush_c", 32'(flush), 32'd1);
    chk("exc_rv_c", 32'(redirect_valid), 32'd0);
    chk("exc_cnt", 32'(event_cnt), 32'd1);
    tick();
    chk("exc_set_off", 32'(cp0_exl_set), 32'd0);
    chk("exc_rv", 32'(redirect_valid), 32'd1);
    chk("exc_rpc", redirect_pc, 32'h4180);
    tick();
    chk("exc_drain1_st", 32'(dbg_state), 32'd3);
    chk("exc_drain1_rv", 32'(redirect_valid), 32'd0);
    chk("exc_drain1_fl", 32'(flush), 32'd1);
    tick();
    chk("exc_drain2_stall", 32'(stall), 32'd1);
    tick();
    chk("exc_idle_stall", 32'(stall), 32'd0);
    chk("exc_idle_flush", 32'(flush), 32'd0);
    chk("exc_vpc_hold", cp0_vpc, 32'h3010);

    // INT beats EXC
    irq = 1'b1; cp0_exl = 1'b0;
    m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4; m_pc = 32'h3100;
    m_bd = 1'b1; m_vaddr = 32'hDEAD_BEE0;
    #1;
    chk("int_kill", 32'(kill_m), 32'd1);
    tick();
    clear_m();
    irq = 1'b0;
    #1;
    chk("int_set", 32'(cp0_exl_set), 32'd1);
    chk("int_code", 32'(cp0_exc_code), 32'd0);
    chk("int_vpc", cp0_vpc, 32'h3100);
    chk("int_bd", 32'(cp0_bd), 32'd1);
    chk("int_vaddr", cp0_vaddr, 32'hDEAD_BEE0);
    chk("int_cnt", 32'(event_cnt), 32'd2);
    tick();
    chk("int_rpc", redirect_pc, 32'h4180);
    tick();
    tick();
    tick();
    chk("int_idle", 32'(dbg_state), 32'd0);

    // ERET with backpressure
    m_valid = 1'b1; m_eret = 1'b1; m_pc = 32'h3200; cp0_epc = 32'h3020;
    #1;
    chk("eret_kill", 32'(kill_m), 32'd1);
    tick();
    clear_m();
    cp0_epc = 32'h0;
    redirect_ready = 1'b0;
    #1;
    chk("eret_clr", 32'(cp0_exl_clr), 32'd1);
    chk("eret_set", 32'(cp0_exl_set), 32'd0);
    chk("eret_cnt", 32'(event_cnt), 32'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", 32'(redirect_valid), 32'd1);
      chk("bp_rpc", redirect_pc, 32'h3020);
      chk("bp_stall", 32'(stall), 32'd1);
      chk("bp_flush", 32'(flush), 32'd1);
      chk("bp_clr", 32'(cp0_exl_clr), 32'd0);
      chk("bp_set", 32'(cp0_exl_set), 32'd0);
      tick();
    end
    redirect_ready = 1'b1;
    #1;
    chk("bp_rv6", 32'(redirect_valid), 32'd1);
    chk("bp_rpc6", redirect_pc, 32'h3020);
    tick();
    chk("bp_drain_st", 32'(dbg_state), 32'd3);
    chk("bp_drain_rv", 32'(redirect_valid), 32'd0);
    tick();
    tick();
    chk("bp_idle", 32'(stall), 32'd0);

    // m_exc and m_eret together -> EXC
    m_valid = 1'b1; m_exc = 1'b1; m_eret = 1'b1; m_exc_code = 5'd10;
    m_pc = 32'h3280; cp0_epc = 32'h3020;
    tick();
    clear_m();
    #1;
    chk("both_set", 32'(cp0_exl_set), 32'd1);
    chk("both_clr", 32'(cp0_exl_clr), 32'd0);
    chk("both_code", 32'(cp0_exc_code), 32'd10);
    tick();
    chk("both_rpc", redirect_pc, 32'h4180);
    tick();
    tick();
    tick();
    chk("both_idle", 32'(dbg_state), 32'd0);
    chk("both_cnt", 32'(event_cnt), 32'd4);

    // Masked interrupt: cp0_exl=1 -> no event
    irq = 1'b1; cp0_exl = 1'b1; m_valid = 1'b1; m_pc = 32'h3290;
    #1;
    chk("mask_kill", 32'(kill_m), 32'd0);
    tick();
    chk("mask_stall", 32'(stall), 32'd0);
    chk("mask_cnt", 32'(event_cnt), 32'd4);

    // Interrupt waits through bubbles
    cp0_exl = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bub_kill", 32'(kill_m), 32'd0);
      tick();
      chk("bub_stall", 32'(stall), 32'd0);
    end
    m_valid = 1'b1; m_pc = 32'h3300;
    #1;
    chk("bub_kill_take", 32'(kill_m), 32'd1);
    tick();
    cp0_exl = 1'b1;  // CP0 sets EXL on entry; irq stays asserted
    #1;
    chk("bub_set", 32'(cp0_exl_set), 32'd1);
    chk("bub_code", 32'(cp0_exc_code), 32'd0);
    chk("bub_vpc", cp0_vpc, 32'h3300);
    chk("bub_cnt", 32'(event_cnt), 32'd5);
    tick();
    tick();
    tick();
    tick();
    chk("held_idle", 32'(dbg_state), 32'd0);
    chk("held_kill", 32'(kill_m), 32'd0);
    tick();
    chk("held_stall", 32'(stall), 32'd0);
    chk("held_cnt", 32'(event_cnt), 32'd5);

    // Reset during REDIRECT
    irq = 1'b0; cp0_exl = 1'b0;
    m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd5; m_pc = 32'h3400;
    m_vaddr = 32'h0000_1234;
    tick();
    clear_m();
    tick();
    chk("rr_rv", 32'(redirect_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rr_state", 32'(dbg_state), 32'd0);
    chk("rr_rv0", 32'(redirect_valid), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    chk("rr_flush", 32'(flush), 32'd0);
    chk("rr_set", 32'(cp0_exl_set), 32'd0);
    chk("rr_rpc", redirect_pc, 32'd0);
    chk("rr_vpc", cp0_vpc, 32'd0);
    chk("rr_vaddr", cp0_vaddr, 32'd0);
    chk("rr_code", 32'(cp0_exc_code), 32'd0);
    chk("rr_cnt", 32'(event_cnt), 32'd0);

    // event_cnt wrap from a forced 16'hFFFF
    force dut.event_cnt_q = 16'hFFFF;
    #1;
    release dut.event_cnt_q;
    #1;
    chk("wrap_pre", 32'(event_cnt), 32'h0000_FFFF);
    m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd6; m_pc = 32'h3500;
    tick();
    clear_m();
    #1;
    chk("wrap_cnt", 32'(event_cnt), 32'd0);
    chk("wrap_set", 32'(cp0_exl_set), 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("wrap_idle", 32'(dbg_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
